// File: rtl/bfm_ahbtoapb_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bfm_ahbtoapb_gen2
// Purpose  : AHB-Lite slave to APB3/APB4 master bridge for the AMBA BFM
//            infrastructure. Slot count and HADDR slot-select field are
//            parameterised; out-of-range slots get a two-cycle AHB ERROR
//            without an APB access. Optional PREADY timeout (TIMEOUT > 0).
//            Optional APB4 PSTRB/PPROT generation via macro
//            BFM_AHBTOAPB_APB4_EN (undefined: both tied to zero).
// Ports    : HCLK, HRESETN (async, active-low)
//            AHB in : HSEL HWRITE HREADYIN HMASTLOCK HADDR HWDATA HTRANS
//                     HSIZE HBURST HPROT
//            AHB out: HRDATA HREADYOUT HRESP
//            APB out: PSEL[NSLOTS] PADDR PWDATA PWRITE PENABLE PSTRB PPROT
//            APB in : PRDATA PREADY PSLVERR
//            TIMEOUT_ERR: one-cycle pulse on a PREADY timeout abort
// Revision : 1.0 - initial release
// ============================================================================
module bfm_ahbtoapb_gen2 #(
    parameter int TPD       = 1,
    parameter int NSLOTS    = 16,
    parameter int SLOT_LSB  = 24,
    parameter int SLOT_BITS = 4,
    parameter int TIMEOUT   = 0
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADYIN,
    input  logic              HMASTLOCK,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [NSLOTS-1:0] PSEL,
    output logic [31:0]       PADDR,
    output logic [31:0]       PWDATA,
    output logic              PWRITE,
    output logic              PENABLE,
    output logic [3:0]        PSTRB,
    output logic [2:0]        PPROT,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              TIMEOUT_ERR
);

    // Timeout counter holds values 0..TIMEOUT-1.
    localparam int                 c_CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int                 c_CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_LAST_I[c_CNT_W-1:0];
    localparam logic [SLOT_BITS:0] c_NSLOTS_EXT = (SLOT_BITS + 1)'(NSLOTS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    state_t                 w_target;

    logic [31:0]            r_addr;
    logic                   r_write;
    logic [2:0]             r_size;
    logic [1:0]             r_prot;
    logic [SLOT_BITS-1:0]   r_slot;
    logic [31:0]            r_pwdata;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_timeout_err;

    logic                   w_accept;
    logic [SLOT_BITS-1:0]   w_slot;
    logic                   w_slot_ok;
    logic                   w_timeout;
    logic                   w_sample;
    logic                   w_capture;
    logic                   w_apb_act;

    // TPD models output delay in the behavioural BFM flow only; the
    // synthesizable bridge has no delays, so the parameter is inert here.
    if (TPD < 0) begin : g_tpd_inert
    end

    assign w_accept  = HSEL & HREADYIN & HTRANS[1];
    assign w_slot    = HADDR[SLOT_LSB +: SLOT_BITS];
    assign w_slot_ok = ({1'b0, w_slot} < c_NSLOTS_EXT);
    assign w_target  = w_slot_ok ? ST_SETUP : ST_ERR1;

    // A late PREADY in the final counted cycle wins over the timeout.
    assign w_timeout = (TIMEOUT > 0) && !PREADY && (r_cnt == c_CNT_LAST);

    // New address phases are only taken when the AHB data phase of the
    // previous transfer is finishing (or there is none).
    assign w_sample  = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                       ((r_state == ST_ACCESS) && PREADY && !PSLVERR);
    assign w_capture = w_sample && w_accept;
    assign w_apb_act = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and AHB-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        PENABLE     = 1'b0;
        HRDATA      = '0;
        PWDATA      = r_pwdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_target;
                end
            end
            ST_SETUP: begin
                HREADYOUT   = 1'b0;
                // HWDATA is only valid in this first data-phase cycle.
                PWDATA      = HWDATA;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PENABLE   = 1'b1;
                HREADYOUT = PREADY & ~PSLVERR;
                HRDATA    = PRDATA;
                if (PREADY) begin
                    if (PSLVERR) begin
                        w_state_nxt = ST_ERR1;
                    end else if (w_accept) begin
                        w_state_nxt = w_target;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_target;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address-phase capture, write-data hold, timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_size        <= '0;
            r_prot        <= '0;
            r_slot        <= '0;
            r_pwdata      <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_prot  <= HPROT[1:0];
                r_slot  <= w_slot;
            end
            if (r_state == ST_SETUP) begin
                r_pwdata <= HWDATA;
            end
            // Staying in ACCESS implies PREADY was low this cycle.
            if ((r_state == ST_ACCESS) && (w_state_nxt == ST_ACCESS)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            r_timeout_err <= (r_state == ST_ACCESS) && w_timeout;
        end
    end

    // ------------------------------------------------------------------
    // APB-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (w_apb_act && (r_slot == SLOT_BITS'(i))) begin
                PSEL[i] = 1'b1;
            end
        end
    end

    assign PADDR       = r_addr;
    assign PWRITE      = r_write;
    assign TIMEOUT_ERR = r_timeout_err;

`ifdef BFM_AHBTOAPB_APB4_EN
    always_comb begin
        PSTRB = '0;
        PPROT = '0;
        if (w_apb_act) begin
            PPROT = {~r_prot[0], 1'b0, r_prot[1]};
            if (r_write) begin
                case (r_size)
                    3'd0:    PSTRB = 4'b0001 << r_addr[1:0];
                    3'd1:    PSTRB = 4'b0011 << {r_addr[1], 1'b0};
                    default: PSTRB = 4'hF;
                endcase
            end
        end
    end
`else
    assign PSTRB = '0;
    assign PPROT = '0;
    wire w_unused_apb4 = &{1'b0, r_size, r_prot};
`endif

    wire w_unused = &{1'b0, HTRANS[0], HBURST, HMASTLOCK, HPROT[3:2]};

endmodule
`default_nettype wire

// File: tb/tb_bfm_ahbtoapb_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bfm_ahbtoapb_gen2
// Purpose  : Self-checking bench for bfm_ahbtoapb_gen2 (NSLOTS=12,
//            TIMEOUT=8). An AHB master issues directed then random
//            transfers; an APB responder inserts per-transfer wait states
//            and errors. Per-transfer expectations (wait states, ERROR
//            cycles, PSEL duration, read data) come from transfer-level rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfm_ahbtoapb_gen2;

    localparam int c_NSLOTS     = 12;
    localparam int c_SLOT_LSB   = 24;
    localparam int c_SLOT_BITS  = 4;
    localparam int c_TIMEOUT    = 8;
    localparam int c_NRAND      = 70;
    localparam int c_MAX_CYCLES = 5000;
`ifdef BFM_AHBTOAPB_APB4_EN
    localparam bit c_APB4 = 1'b1;
`else
    localparam bit c_APB4 = 1'b0;
`endif

    logic                HCLK;
    logic                HRESETN;
    logic                HSEL, HWRITE, HMASTLOCK;
    logic                HREADYIN;
    logic [31:0]         HADDR, HWDATA;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE, HBURST;
    logic [3:0]          HPROT;
    logic [31:0]         HRDATA;
    logic                HREADYOUT, HRESP;
    logic [c_NSLOTS-1:0] PSEL;
    logic [31:0]         PADDR, PWDATA;
    logic                PWRITE, PENABLE;
    logic [3:0]          PSTRB;
    logic [2:0]          PPROT;
    logic [31:0]         PRDATA;
    logic                PREADY, PSLVERR;
    logic                TIMEOUT_ERR;

    // Single-slave system: the bus HREADY is this slave's HREADYOUT.
    assign HREADYIN = HREADYOUT;

    bfm_ahbtoapb_gen2 #(
        .TPD       (1),
        .NSLOTS    (c_NSLOTS),
        .SLOT_LSB  (c_SLOT_LSB),
        .SLOT_BITS (c_SLOT_BITS),
        .TIMEOUT   (c_TIMEOUT)
    ) u_dut (
        .HCLK        (HCLK),
        .HRESETN     (HRESETN),
        .HSEL        (HSEL),
        .HWRITE      (HWRITE),
        .HREADYIN    (HREADYIN),
        .HMASTLOCK   (HMASTLOCK),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HTRANS      (HTRANS),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .PSEL        (PSEL),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PENABLE     (PENABLE),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
        int          gap;
    } txn_t;

    txn_t txns[$];
    txn_t t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                input logic [3:0] prot, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits, input logic slverr,
                                input int gap);
        txn_t x;
        x.addr = addr; x.write = write; x.size = size; x.prot = prot; x.wdata = wdata;
        x.rdata = rdata; x.waits = waits; x.slverr = slverr; x.gap = gap;
        return x;
    endfunction

    function automatic int slot_of(input txn_t x);
        return int'(x.addr[c_SLOT_LSB +: c_SLOT_BITS]);
    endfunction

    // Byte lanes touched by a write: a block of 2**size bytes at the
    // size-aligned offset inside the word.
    function automatic logic [31:0] exp_strb(input txn_t x);
        int nbytes;
        int off;
        if (!c_APB4 || !x.write) return 32'h0;
        nbytes = 1 << int'(x.size);
        off    = (int'(x.addr[1:0]) / nbytes) * nbytes;
        return 32'(((1 << nbytes) - 1) << off) & 32'hF;
    endfunction

    function automatic logic [31:0] exp_pprot(input txn_t x);
        if (!c_APB4) return 32'h0;
        return {29'h0, ~x.prot[0], 1'b0, x.prot[1]};
    endfunction

    // Master / responder / per-transfer bookkeeping
    int   ap_idx, dp_idx, nxt, gap_left, acc_cnt, cyc;
    int   st_low, st_psel, st_pen, st_hresp, st_to;
    int   e_low, e_psel, e_hresp;
    logic hr_now, pen_now;
    logic bad, tmo, err;

    task automatic drive_idle_addr();
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HSIZE  = 3'($urandom_range(0, 2));
        HPROT  = 4'($urandom);
        case ($urandom_range(0, 2))
            0:       begin HSEL = 1'b0; HTRANS = 2'($urandom); end
            1:       begin HSEL = 1'b1; HTRANS = {1'b0, 1'($urandom)}; end
            default: begin HSEL = 1'b0; HTRANS = 2'b10; end
        endcase
    endtask

    task automatic gen_random(input int n);
        logic [31:0] a;
        int          slot, size, r, w;
        for (int i = 0; i < n; i++) begin
            slot = ($urandom_range(0, 4) == 0) ? $urandom_range(c_NSLOTS, 15) : $urandom_range(0, c_NSLOTS - 1);
            size = $urandom_range(0, 2);
            a    = $urandom;
            a[27:24] = 4'(slot);
            if (size == 1) a[0] = 1'b0;
            if (size == 2) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 2);
            else if (r < 8) w = $urandom_range(c_TIMEOUT - 2, c_TIMEOUT + 1);
            else            w = $urandom_range(3, 5);
            txns.push_back(mk(a, 1'($urandom), 3'(size), 4'($urandom), $urandom, $urandom, w,
                              ($urandom_range(0, 6) == 0),
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0));
        end
    endtask

    initial begin
        HRESETN = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HMASTLOCK = 1'b0; HADDR = '0; HWDATA = '0;
        HTRANS = 2'b00; HSIZE = '0; HBURST = '0; HPROT = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Directed transfers first, then random ones.
        txns.push_back(mk(32'h0300_0010, 1'b1, 3'd2, 4'b0011, 32'hA5A5_1234, 32'h0, 0, 1'b0, 0));
        txns.push_back(mk(32'h0100_0004, 1'b0, 3'd2, 4'b0001, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1));
        txns.push_back(mk(32'h0C00_0000, 1'b1, 3'd2, 4'b0000, 32'h1111_2222, 32'h0, 0, 1'b0, 0));
        txns.push_back(mk(32'h0200_0008, 1'b1, 3'd2, 4'b0010, 32'h3333_4444, 32'h0, 1, 1'b1, 0));
        txns.push_back(mk(32'h0200_000C, 1'b1, 3'd2, 4'b0000, 32'h5555_6666, 32'h0, 0, 1'b0, 0));
        txns.push_back(mk(32'h0400_0000, 1'b0, 3'd2, 4'b0001, 32'h0, 32'h7777_8888, 100, 1'b0, 1));
        txns.push_back(mk(32'h0B00_0000, 1'b1, 3'd2, 4'b0011, 32'h9999_AAAA, 32'h0, c_TIMEOUT - 1, 1'b0, 0));
        txns.push_back(mk(32'h0000_0002, 1'b1, 3'd1, 4'b0001, 32'hBBBB_CCCC, 32'h0, 0, 1'b0, 0));
        txns.push_back(mk(32'h0000_0003, 1'b1, 3'd0, 4'b0010, 32'hDDDD_EEEE, 32'h0, 0, 1'b0, 0));
        txns.push_back(mk(32'h0F00_0000, 1'b0, 3'd2, 4'b0000, 32'h0, 32'h1234_5678, 0, 1'b1, 0));
        gen_random(c_NRAND);

        // Reset values
        repeat (3) @(negedge HCLK);
        #1;
        check_eq("rst_hreadyout", HREADYOUT, 1);
        check_eq("rst_hresp", HRESP, 0);
        check_eq("rst_psel", PSEL, 0);
        check_eq("rst_paddr", PADDR, 0);
        check_eq("rst_pwdata", PWDATA, 0);
        check_eq("rst_pwrite", PWRITE, 0);
        check_eq("rst_penable", PENABLE, 0);
        check_eq("rst_pstrb", PSTRB, 0);
        check_eq("rst_pprot", PPROT, 0);
        check_eq("rst_timeout_err", TIMEOUT_ERR, 0);
        check_eq("rst_hrdata", HRDATA, 0);
        @(negedge HCLK);
        HRESETN = 1'b1;

        ap_idx = -1; dp_idx = -1; nxt = 0; gap_left = txns[0].gap; acc_cnt = 0; cyc = 0;
        st_low = 0; st_psel = 0; st_pen = 0; st_hresp = 0; st_to = 0;

        while ((nxt < txns.size() || ap_idx >= 0 || dp_idx >= 0) && cyc < c_MAX_CYCLES) begin
            cyc++;
            HMASTLOCK = 1'($urandom);
            HBURST    = 3'($urandom);
            if (ap_idx >= 0) begin
                t = txns[ap_idx];
                HSEL = 1'b1; HTRANS = 2'b10; HADDR = t.addr; HWRITE = t.write;
                HSIZE = t.size; HPROT = t.prot;
            end else begin
                drive_idle_addr();
            end
            HWDATA = $urandom;
            if (dp_idx >= 0 && txns[dp_idx].write) HWDATA = txns[dp_idx].wdata;

            // APB responder
            if (dp_idx >= 0 && PENABLE) begin
                t       = txns[dp_idx];
                PREADY  = (acc_cnt >= t.waits);
                PSLVERR = PREADY ? t.slverr : 1'($urandom);
                PRDATA  = PREADY ? t.rdata : $urandom;
            end else begin
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end

            #1;
            hr_now  = HREADYOUT;
            pen_now = PENABLE;
            if (dp_idx < 0) begin
                check_eq("idle_hreadyout", HREADYOUT, 1);
                check_eq("idle_hresp", HRESP, 0);
                check_eq("idle_psel", PSEL, 0);
                check_eq("idle_hrdata", HRDATA, 0);
                check_eq("idle_timeout_err", TIMEOUT_ERR, 0);
            end else begin
                t = txns[dp_idx];
                if (!HREADYOUT) st_low++;
                if (HRESP) st_hresp++;
                if (PENABLE) st_pen++;
                if (TIMEOUT_ERR) st_to++;
                if (PSEL != 0) begin
                    st_psel++;
                    check_eq("psel", PSEL, 32'(1) << slot_of(t));
                    check_eq("paddr", PADDR, t.addr);
                    check_eq("pwrite", PWRITE, t.write);
                    if (t.write) check_eq("pwdata", PWDATA, t.wdata);
                    check_eq("pstrb", PSTRB, exp_strb(t));
                    check_eq("pprot", PPROT, exp_pprot(t));
                end
                if (HREADYOUT) begin
                    bad = (slot_of(t) >= c_NSLOTS);
                    tmo = !bad && (t.waits >= c_TIMEOUT);
                    err = !bad && !tmo && t.slverr;
                    if (bad)      begin e_low = 1;                 e_psel = 0; end
                    else if (tmo) begin e_low = c_TIMEOUT + 2;     e_psel = c_TIMEOUT + 1; end
                    else if (err) begin e_low = t.waits + 3;       e_psel = t.waits + 2; end
                    else          begin e_low = t.waits + 1;       e_psel = t.waits + 2; end
                    e_hresp = (bad || tmo || err) ? 2 : 0;
                    check_eq("wait_states", 32'(st_low), 32'(e_low));
                    check_eq("hresp_cycles", 32'(st_hresp), 32'(e_hresp));
                    check_eq("psel_cycles", 32'(st_psel), 32'(e_psel));
                    check_eq("penable_cycles", 32'(st_pen), 32'((e_psel > 0) ? e_psel - 1 : 0));
                    check_eq("timeout_pulses", 32'(st_to), 32'(tmo ? 1 : 0));
                    if (!bad && !tmo && !err && !t.write) check_eq("hrdata", HRDATA, t.rdata);
                end
            end

            @(posedge HCLK);
            if (pen_now) acc_cnt++;
            if (hr_now) begin
                dp_idx = ap_idx;
                acc_cnt = 0;
                st_low = 0; st_psel = 0; st_pen = 0; st_hresp = 0; st_to = 0;
                ap_idx = -1;
                if (nxt < txns.size()) begin
                    if (gap_left == 0) begin
                        ap_idx   = nxt;
                        nxt++;
                        gap_left = (nxt < txns.size()) ? txns[nxt].gap : 0;
                    end else begin
                        gap_left--;
                    end
                end
            end
            @(negedge HCLK);
        end
        check_eq("cycle_budget", 32'(cyc < c_MAX_CYCLES), 1);

        // Reset asserted in the middle of an APB access
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0200_0040; HWRITE = 1'b1; HSIZE = 3'd2;
        HPROT = 4'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(posedge HCLK); @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1234_5678;
        #1 check_eq("midrst_setup_psel", PSEL, 32'h4);
        @(posedge HCLK); @(negedge HCLK);
        #1 check_eq("midrst_access_penable", PENABLE, 1);
        HRESETN = 1'b0;
        #1;
        check_eq("midrst_psel", PSEL, 0);
        check_eq("midrst_penable", PENABLE, 0);
        check_eq("midrst_hreadyout", HREADYOUT, 1);
        check_eq("midrst_paddr", PADDR, 0);
        check_eq("midrst_pwdata", PWDATA, 0);
        check_eq("midrst_pwrite", PWRITE, 0);
        @(posedge HCLK); @(negedge HCLK);
        HRESETN = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        #1;
        check_eq("post_rst_psel", PSEL, 0);
        check_eq("post_rst_hreadyout", HREADYOUT, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
